basic_assert_checker: RTL and testbench
=======================================

# basic_assert_checker

Synthesizable RTL checker for the temporal property "a |-> ##[MIN_DELAY:MAX_DELAY] b", the RTL equivalent of a concurrent SVA assertion. It samples `a` and `b` on every rising clock edge and tracks overlapping attempts. It reports each clock's outcome as registered pulses for pass and fail, plus a level showing that an attempt is in flight. It sits beside the logic it monitors and feeds status/interrupt logic or a simulation monitor.

## Interface
- MIN_DELAY, default 1: earliest cycle offset (from the `a` sample) at which `b` may satisfy an attempt; range 0..MAX_DELAY.
- MAX_DELAY, default 1: latest offset; range MIN_DELAY..32, and at least 1. The defaults give "a |=> b".
- One clock; reset is asynchronous and active-high.
- clk  in  1  clock; all sampling on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  1  antecedent; each edge with `a`=1 starts a new attempt.
- b  in  1  consequent.
- assertion_pass  out  1  registered; 1 for one cycle when at least one attempt passed at the preceding edge.
- assertion_fail  out  1  registered; 1 for one cycle when at least one attempt failed at the preceding edge.
- assertion_active  out  1  registered; 1 while at least one attempt is unresolved after the preceding edge.

## Operation
- Inputs are sampled only at edges where `rst`=0.
- Attempt start:
  - `a`=1 at edge N starts an attempt with age 0.
  - At edge N+k the attempt has age k.
  - Attempts are independent; a new one starts every cycle `a`=1, even while others are pending.
- Attempt resolution at an edge with age k:
  - MIN_DELAY ≤ k ≤ MAX_DELAY and `b`=1: the attempt passes and retires.
  - k = MAX_DELAY and `b`=0: the attempt fails and retires.
  - Any other case: the attempt stays pending.
- With MIN_DELAY=0, an attempt whose start edge also has `b`=1 passes at that same edge.
- A single `b`=1 sample satisfies every pending attempt inside its window at once (pass pulse of 1).
- Vacuous cycles, where `a`=0 and nothing resolves, produce no pass.
- At each edge:
  - assertion_pass is set to (any pass at this edge).
  - assertion_fail is set to (any fail at this edge).
  - Both may be 1 together: attempts of different ages can resolve with different outcomes.
  - assertion_active is set to (any attempt still pending after this edge, including one just started).
- State is a pending-attempt shift vector of MAX_DELAY+1 bits indexed by age. No counters or arithmetic beyond the shift and window masks.

## Timing
- Reset:
  - Asserting `rst` immediately clears all pending attempts and drives all three outputs to 0, regardless of clock.
  - Attempts in flight at reset are discarded and never reported.
  - The first edge with `rst`=0 samples normally.
- Latency: the outcome decided at edge N is visible on the outputs from edge N until edge N+1, i.e. one register stage and no extra delay.
- Pulses last exactly one cycle unless a further resolution occurs at the next edge.
- Fail is reported at edge start+MAX_DELAY. The earliest pass is at edge start+MIN_DELAY.
- No handshake; inputs are treated as synchronous to `clk`.

## Structure
- Package `basic_assert_checker_pkg` holds:
  - constant MAX_DELAY_LIMIT = 32;
  - an elaboration-time check function for the parameter range.
- Out-of-range parameters are an elaboration error.
- Single module; no sub-module. The window masks are generate-time constants.

## Test plan
- Reset: hold `rst`=1 for 2 cycles while toggling `a`/`b` → all outputs 0; release, `a`=0 for 10 cycles → no pass/fail, assertion_active=0.
- Defaults, pass: `a`=1 at edge 3 only, `b`=1 at edge 4 → assertion_active=1 after edge 3; assertion_pass=1 after edge 4 for exactly one cycle; assertion_fail=0 throughout.
- Defaults, fail: `a`=1 at edge 3, `b`=0 at edge 4 → assertion_fail=1 after edge 4 for one cycle; assertion_active=0 after edge 4.
- Defaults, overlap: `a`=1 at edges 3–5, `b` = 1,0,1 at edges 4,5,6 → pass after edges 4 and 6; fail after edge 5; assertion_active=1 from edge 3 through edge 5.
- MIN_DELAY=1, MAX_DELAY=3:
  - `a`=1 at edges 2 and 4, `b`=1 at edge 5 only → single pass pulse after edge 5 (both attempts satisfied); no fail.
  - Repeat with `b`=0 throughout → fail after edge 5 and after edge 7.
- Reset mid-operation: `a`=1 at edge 3, then `rst` asserted between edges 3 and 4 → outputs clear immediately; no fail is ever reported for that attempt.

Source files
------------

// File: rtl/basic_assert_checker_pkg.sv
// Shared constants and elaboration helpers for the a |-> ##[MIN:MAX] b checker.
package basic_assert_checker_pkg;

  localparam int unsigned MAX_DELAY_LIMIT = 32;

  // True when the delay window is legal: 1 <= max <= limit and min <= max.
  function automatic bit params_ok(input int unsigned min_d, input int unsigned max_d);
    return (max_d >= 1) && (max_d <= MAX_DELAY_LIMIT) && (min_d <= max_d);
  endfunction

  // Bit k set when an attempt of age k may be satisfied by b.
  function automatic logic [MAX_DELAY_LIMIT:0] window_mask(input int unsigned min_d,
                                                            input int unsigned max_d);
    logic [MAX_DELAY_LIMIT:0] m;
    m = '0;
    for (int unsigned i = 0; i <= MAX_DELAY_LIMIT; i++) begin
      m[i] = (i >= min_d) && (i <= max_d);
    end
    return m;
  endfunction

endpackage

// File: rtl/basic_assert_checker.sv
// RTL checker for "a |-> ##[MIN_DELAY:MAX_DELAY] b" with overlapping attempts.
module basic_assert_checker
  import basic_assert_checker_pkg::*;
#(
  parameter int unsigned MIN_DELAY = 1,
  parameter int unsigned MAX_DELAY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic assertion_pass,
  output logic assertion_fail,
  output logic assertion_active
);

  if (!params_ok(MIN_DELAY, MAX_DELAY)) begin : g_bad_params
    $error("basic_assert_checker: illegal MIN_DELAY/MAX_DELAY");
  end

  localparam logic [MAX_DELAY_LIMIT:0] WIN_FULL = window_mask(MIN_DELAY, MAX_DELAY);
  localparam logic [MAX_DELAY:0]       WIN      = WIN_FULL[MAX_DELAY:0];

  // pend_q[k]: an attempt that had age k at the last edge and is still open.
  // The top bit is never left set since age MAX_DELAY always retires.
  logic [MAX_DELAY:0] pend_q, pend_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic [MAX_DELAY:0] cur;
  logic [MAX_DELAY:0] hit;

  // Age every open attempt by one, add a new one, then resolve against b.
  always_comb begin
    cur    = {pend_q[MAX_DELAY-1:0], a};
    hit    = b ? (cur & WIN) : '0;
    pass_d = |hit;
    fail_d = cur[MAX_DELAY] & ~b;
    pend_d = cur & ~hit;
    pend_d[MAX_DELAY] = 1'b0;
  end

  // State and outcome pulses; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign assertion_pass   = pass_q;
  assign assertion_fail   = fail_q;
  assign assertion_active = |pend_q;

endmodule

// File: tb/tb_basic_assert_checker.sv
// Directed self-checking bench for basic_assert_checker.
module tb_basic_assert_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a1 = 1'b0, b1 = 1'b0;   // defaults: a |=> b
  logic a3 = 1'b0, b3 = 1'b0;   // window 1..3
  logic az = 1'b0, bz = 1'b0;   // window 0..2
  logic p1, f1, v1, p3, f3, v3, pz, fz, vz;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  basic_assert_checker u_def (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .assertion_pass(p1), .assertion_fail(f1), .assertion_active(v1)
  );

  basic_assert_checker #(.MIN_DELAY(1), .MAX_DELAY(3)) u_win (
    .clk(clk), .rst(rst), .a(a3), .b(b3),
    .assertion_pass(p3), .assertion_fail(f3), .assertion_active(v3)
  );

  basic_assert_checker #(.MIN_DELAY(0), .MAX_DELAY(2)) u_zero (
    .clk(clk), .rst(rst), .a(az), .b(bz),
    .assertion_pass(pz), .assertion_fail(fz), .assertion_active(vz)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic p, input logic f, input logic v,
                      input logic ep, input logic ef, input logic ev);
    chk({tag, ".pass"}, p, ep);
    chk({tag, ".fail"}, f, ef);
    chk({tag, ".active"}, v, ev);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two edges with inputs toggling.
    a1 = 1; b1 = 1; a3 = 1; b3 = 1; az = 1; bz = 1;
    tick;
    chk3("rst0.def", p1, f1, v1, 0, 0, 0);
    chk3("rst0.win", p3, f3, v3, 0, 0, 0);
    a1 = 0; b1 = 0; a3 = 0; b3 = 0; az = 0; bz = 1;
    tick;
    chk3("rst1.def", p1, f1, v1, 0, 0, 0);
    chk3("rst1.zero", pz, fz, vz, 0, 0, 0);
    rst = 0; bz = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk3("idle.def", p1, f1, v1, 0, 0, 0);
    end

    // Defaults, pass.
    a1 = 1; b1 = 0; tick; chk3("dpass.e3", p1, f1, v1, 0, 0, 1);
    a1 = 0; b1 = 1; tick; chk3("dpass.e4", p1, f1, v1, 1, 0, 0);
    a1 = 0; b1 = 0; tick; chk3("dpass.e5", p1, f1, v1, 0, 0, 0);

    // Defaults, fail.
    a1 = 1; b1 = 0; tick; chk3("dfail.e3", p1, f1, v1, 0, 0, 1);
    a1 = 0; b1 = 0; tick; chk3("dfail.e4", p1, f1, v1, 0, 1, 0);
    tick;                 chk3("dfail.e5", p1, f1, v1, 0, 0, 0);

    // Defaults, overlapping attempts.
    a1 = 1; b1 = 0; tick; chk3("dovl.e3", p1, f1, v1, 0, 0, 1);
    a1 = 1; b1 = 1; tick; chk3("dovl.e4", p1, f1, v1, 1, 0, 1);
    a1 = 1; b1 = 0; tick; chk3("dovl.e5", p1, f1, v1, 0, 1, 1);
    a1 = 0; b1 = 1; tick; chk3("dovl.e6", p1, f1, v1, 1, 0, 0);
    a1 = 0; b1 = 0; tick; chk3("dovl.e7", p1, f1, v1, 0, 0, 0);

    // Window 1..3: one b satisfies two attempts at once.
    a3 = 1; tick;         chk3("wpass.e2", p3, f3, v3, 0, 0, 1);
    a3 = 0; tick;         chk3("wpass.e3", p3, f3, v3, 0, 0, 1);
    a3 = 1; tick;         chk3("wpass.e4", p3, f3, v3, 0, 0, 1);
    a3 = 0; b3 = 1; tick; chk3("wpass.e5", p3, f3, v3, 1, 0, 0);
    b3 = 0; tick;         chk3("wpass.e6", p3, f3, v3, 0, 0, 0);

    // Window 1..3: same attempts, b never arrives.
    a3 = 1; tick;         chk3("wfail.e2", p3, f3, v3, 0, 0, 1);
    a3 = 0; tick;         chk3("wfail.e3", p3, f3, v3, 0, 0, 1);
    a3 = 1; tick;         chk3("wfail.e4", p3, f3, v3, 0, 0, 1);
    a3 = 0; tick;         chk3("wfail.e5", p3, f3, v3, 0, 1, 1);
    tick;                 chk3("wfail.e6", p3, f3, v3, 0, 0, 1);
    tick;                 chk3("wfail.e7", p3, f3, v3, 0, 1, 0);
    tick;                 chk3("wfail.e8", p3, f3, v3, 0, 0, 0);

    // Window 1..3: b at age 0 is too early, pass later at age 2.
    a3 = 1; b3 = 1; tick; chk3("wearly.e1", p3, f3, v3, 0, 0, 1);
    a3 = 0; b3 = 0; tick; chk3("wearly.e2", p3, f3, v3, 0, 0, 1);
    b3 = 1; tick;         chk3("wearly.e3", p3, f3, v3, 1, 0, 0);
    b3 = 0; tick;         chk3("wearly.e4", p3, f3, v3, 0, 0, 0);

    // Window 0..2: same-edge pass, then a fail at age 2.
    az = 1; bz = 1; tick; chk3("zero.same", pz, fz, vz, 1, 0, 0);
    az = 1; bz = 0; tick; chk3("zero.e1", pz, fz, vz, 0, 0, 1);
    az = 0; tick;         chk3("zero.e2", pz, fz, vz, 0, 0, 1);
    tick;                 chk3("zero.e3", pz, fz, vz, 0, 1, 0);
    tick;                 chk3("zero.e4", pz, fz, vz, 0, 0, 0);

    // Reset mid-flight: outputs clear at once, attempt never reported.
    a1 = 1; b1 = 0; tick; chk3("mrst.e3", p1, f1, v1, 0, 0, 1);
    a1 = 0;
    #2 rst = 1;
    #1 chk3("mrst.async", p1, f1, v1, 0, 0, 0);
    tick; chk3("mrst.held", p1, f1, v1, 0, 0, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk3("mrst.after", p1, f1, v1, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
